// File: rtl/vector_exec_sequencer_pkg.sv
// Shared definitions for the vector execute stage: ALU opcode encodings and
// the sequencer FSM state type. Also imported by the decode stage.
package vector_exec_sequencer_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_XOR = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_INC = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vector_exec_sequencer_alu.sv
// Scalar ALU shared by all vector lanes. Purely combinational.
// Ports:
//   operation_select  opcode (see package OP_*)
//   operand1/operand2 element operands, dataSize bits
//   result            truncated result, no saturation
//   neg_flag          sign of operand1 flipped in a nonzero result
//   zero_flag         result is zero
module alu
  import vector_exec_sequencer_pkg::*;
#(
  parameter int unsigned dataSize = 8
) (
  input  logic [OP_W-1:0]     operation_select,
  input  logic [dataSize-1:0] operand1,
  input  logic [dataSize-1:0] operand2,
  output logic [dataSize-1:0] result,
  output logic                neg_flag,
  output logic                zero_flag
);

  localparam int unsigned PROD_W = 2 * dataSize;
  localparam logic [dataSize-1:0] SHIFT_LIM = dataSize'(dataSize);
  localparam logic [dataSize-1:0] ONE       = dataSize'(1);

  logic [PROD_W-1:0] product;

  assign product = PROD_W'(operand1) * PROD_W'(operand2);

  // Operation select; every result is truncated to dataSize bits
  always_comb begin
    result = '0;
    case (operation_select)
      OP_NOP: result = '0;
      OP_XOR: result = operand1 ^ operand2;
      OP_ADD: result = operand1 + operand2;
      OP_SUB: result = operand1 - operand2;
      OP_MUL: result = product[dataSize-1:0];
      // Shift amount is the whole operand2; oversize amounts flush to zero
      OP_SHR: result = (operand2 >= SHIFT_LIM) ? '0 : (operand1 >> operand2);
      OP_SHL: result = (operand2 >= SHIFT_LIM) ? '0 : (operand1 << operand2);
      OP_INC: result = operand1 + ONE;
      default: result = '0;
    endcase
  end

  assign zero_flag = (result == '0);
  assign neg_flag  = (operand1[dataSize-1] != result[dataSize-1]) && !zero_flag;

endmodule

// File: rtl/vector_exec_sequencer.sv
// Execute-stage sequencer: accepts one vector instruction, streams its lanes
// one per cycle through a single shared ALU, and presents the assembled result
// vector and per-lane flag masks to writeback over valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop any in-flight vector, return to IDLE
//   in_valid/in_ready   instruction handshake (in_op, in_vec_a, in_vec_b, in_dest)
//   out_valid/out_ready result handshake (out_vec, out_neg_mask, out_zero_mask, out_dest)
module vector_exec_sequencer
  import vector_exec_sequencer_pkg::*;
#(
  parameter int unsigned dataSize    = 8,
  parameter int unsigned lanes       = 4,
  parameter int unsigned regAddrSize = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OP_W-1:0]             in_op,
  input  logic [lanes*dataSize-1:0]   in_vec_a,
  input  logic [lanes*dataSize-1:0]   in_vec_b,
  input  logic [regAddrSize-1:0]      in_dest,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [lanes*dataSize-1:0]   out_vec,
  output logic [lanes-1:0]            out_neg_mask,
  output logic [lanes-1:0]            out_zero_mask,
  output logic [regAddrSize-1:0]      out_dest
);

  localparam int unsigned VEC_W = lanes * dataSize;
  localparam int unsigned CNT_W = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(lanes - 1);

  state_e state;
  state_e state_next;

  logic [CNT_W-1:0]    lane_cnt;
  logic [OP_W-1:0]     op_q;
  logic [VEC_W-1:0]    vec_a_q;
  logic [VEC_W-1:0]    vec_b_q;
  logic [dataSize-1:0] a_lane [lanes];
  logic [dataSize-1:0] b_lane [lanes];
  logic [dataSize-1:0] lane_res;
  logic                lane_neg;
  logic                lane_zero;
  logic                accept;
  logic                last_lane;

  // Handshake; a DONE vector being taken frees the slot in the same cycle
  assign in_ready  = !rst && !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign last_lane = (lane_cnt == LAST_LANE);

  // Lane views of the captured operands
  for (genvar g = 0; g < lanes; g++) begin : g_slice
    assign a_lane[g] = vec_a_q[g*dataSize +: dataSize];
    assign b_lane[g] = vec_b_q[g*dataSize +: dataSize];
  end

  alu #(
    .dataSize(dataSize)
  ) u_alu (
    .operation_select(op_q),
    .operand1        (a_lane[lane_cnt]),
    .operand2        (b_lane[lane_cnt]),
    .result          (lane_res),
    .neg_flag        (lane_neg),
    .zero_flag       (lane_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last_lane) state_next = DONE;
      DONE: if (out_ready) state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Operand capture, lane counting and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt      <= '0;
      op_q          <= OP_NOP;
      vec_a_q       <= '0;
      vec_b_q       <= '0;
      out_vec       <= '0;
      out_neg_mask  <= '0;
      out_zero_mask <= '0;
      out_dest      <= '0;
    end else if (accept) begin
      lane_cnt      <= '0;
      op_q          <= in_op;
      vec_a_q       <= in_vec_a;
      vec_b_q       <= in_vec_b;
      out_vec       <= '0;
      out_neg_mask  <= '0;
      out_zero_mask <= '0;
      out_dest      <= in_dest;
    end else if ((state == RUN) && !flush) begin
      for (int i = 0; i < lanes; i++) begin
        if (lane_cnt == CNT_W'(i)) begin
          out_vec[i*dataSize +: dataSize] <= lane_res;
          out_neg_mask[i]                 <= lane_neg;
          out_zero_mask[i]                <= lane_zero;
        end
      end
      lane_cnt <= last_lane ? '0 : lane_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Self-checking bench for vector_exec_sequencer (dataSize=8, lanes=4).
// A transaction-level model predicts the whole result vector at accept time
// and the handshake timing; a negedge process compares the DUT every cycle.
module tb_vector_exec_sequencer;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int RW = 4;
  localparam int VW = DW * LN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'b000;
  logic [VW-1:0] in_vec_a = '0;
  logic [VW-1:0] in_vec_b = '0;
  logic [RW-1:0] in_dest = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_vec;
  logic [LN-1:0] out_neg_mask;
  logic [LN-1:0] out_zero_mask;
  logic [RW-1:0] out_dest;

  int errors = 0;
  int checks = 0;

  vector_exec_sequencer #(
    .dataSize(DW), .lanes(LN), .regAddrSize(RW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_vec_a(in_vec_a), .in_vec_b(in_vec_b), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_neg_mask(out_neg_mask), .out_zero_mask(out_zero_mask), .out_dest(out_dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Element-level reference arithmetic
  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
    int xi, yi, ri;
    xi = int'(x);
    yi = int'(y);
    case (op)
      3'd1: ri = xi ^ yi;
      3'd2: ri = xi + yi;
      3'd3: ri = xi - yi;
      3'd4: ri = xi * yi;
      3'd5: ri = (yi >= DW) ? 0 : (xi >> yi);
      3'd6: ri = (yi >= DW) ? 0 : (xi << yi);
      3'd7: ri = xi + 1;
      default: ri = 0;
    endcase
    return ri[DW-1:0];
  endfunction

  function automatic void model_vec(input logic [2:0] op, input logic [VW-1:0] a,
                                    input logic [VW-1:0] b, output logic [VW-1:0] v,
                                    output logic [LN-1:0] ng, output logic [LN-1:0] zr);
    logic [DW-1:0] x, y, r;
    v = '0; ng = '0; zr = '0;
    for (int i = 0; i < LN; i++) begin
      x = a[i*DW +: DW];
      y = b[i*DW +: DW];
      r = ref_alu(op, x, y);
      v[i*DW +: DW] = r;
      zr[i] = (r == 0);
      ng[i] = (x[DW-1] != r[DW-1]) && (r != 0);
    end
  endfunction

  // Transaction model: m_run counts lane cycles left, m_valid marks a held result
  bit            m_valid = 1'b0;
  int            m_run = 0;
  logic [VW-1:0] m_vec = '0;
  logic [LN-1:0] m_neg = '0;
  logic [LN-1:0] m_zero = '0;
  logic [RW-1:0] m_dest = '0;

  function automatic bit model_ready();
    return !rst && !flush && ((!m_valid && m_run == 0) || (m_valid && out_ready));
  endfunction

  always @(posedge clk) begin : model_upd
    logic [VW-1:0] tv;
    logic [LN-1:0] tn, tz;
    if (rst || flush) begin
      m_valid <= 1'b0;
      m_run   <= 0;
    end else if (in_valid && model_ready()) begin
      model_vec(in_op, in_vec_a, in_vec_b, tv, tn, tz);
      m_vec   <= tv;
      m_neg   <= tn;
      m_zero  <= tz;
      m_dest  <= in_dest;
      m_run   <= LN;
      m_valid <= 1'b0;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end else if (m_run > 0) begin
      m_run <= m_run - 1;
      if (m_run == 1) m_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(model_ready()));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_vec", 64'(out_vec), 64'(m_vec));
      chk("out_neg_mask", 64'(out_neg_mask), 64'(m_neg));
      chk("out_zero_mask", 64'(out_zero_mask), 64'(m_zero));
      chk("out_dest", 64'(out_dest), 64'(m_dest));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction until accepted; returns just after the accept edge
  task automatic send(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [RW-1:0] d);
    logic r;
    r = 1'b0;
    in_valid = 1'b1; in_op = op; in_vec_a = a; in_vec_b = b; in_dest = d;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      r = in_ready;
      step();
      if (r) break;
    end
    in_valid = 1'b0;
    chk("send_accepted", 64'(r), 64'd1);
  endtask

  // Count negedges until out_valid; returns at that negedge
  task automatic wait_valid(output int n);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic run_vec(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [RW-1:0] d, output int n);
    send(op, a, b, d);
    wait_valid(n);
  endtask

  task automatic pop();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    logic acc;

    repeat (3) step();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_vec", 64'(out_vec), 64'd0);
    chk("rst_masks", 64'({out_neg_mask, out_zero_mask}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    step();

    // Add with carry-out, sign flip and zero lanes
    run_vec(3'b010, 32'h10FF7F01, 32'hF0010101, 4'h3, n);
    chk("add_latency", 64'(n), 64'd5);
    chk("add_vec", 64'(out_vec), 64'h00008002);
    chk("add_zero", 64'(out_zero_mask), 64'b1100);
    chk("add_neg", 64'(out_neg_mask), 64'b0010);
    chk("add_dest", 64'(out_dest), 64'h3);
    pop();

    run_vec(3'b011, 32'h00000005, 32'h00000006, 4'h4, n);
    chk("sub_vec", 64'(out_vec), 64'h000000FF);
    chk("sub_neg", 64'(out_neg_mask), 64'b0001);
    chk("sub_zero", 64'(out_zero_mask), 64'b1110);
    pop();

    run_vec(3'b100, 32'h10101010, 32'h10101010, 4'h5, n);
    chk("mul_vec", 64'(out_vec), 64'd0);
    chk("mul_zero", 64'(out_zero_mask), 64'b1111);
    pop();

    run_vec(3'b101, 32'h80808080, 32'h09090909, 4'h6, n);
    chk("shr_vec", 64'(out_vec), 64'd0);
    chk("shr_zero", 64'(out_zero_mask), 64'b1111);
    chk("shr_neg", 64'(out_neg_mask), 64'b0000);
    pop();

    run_vec(3'b000, VW'($urandom), VW'($urandom), 4'h7, n);
    chk("nop_vec", 64'(out_vec), 64'd0);
    chk("nop_masks", 64'({out_neg_mask, out_zero_mask}), 64'h0F);
    pop();

    // Backpressure in DONE, then pop and accept in the same cycle
    run_vec(3'b001, 32'h12345678, 32'hFFFFFFFF, 4'h8, n);
    repeat (10) step();
    @(negedge clk);
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_vec", 64'(out_vec), 64'hEDCBA987);
    chk("hold_neg", 64'(out_neg_mask), 64'b1111);
    chk("hold_ready", 64'(in_ready), 64'd0);
    step();
    out_ready = 1'b1;
    send(3'b001, 32'hFFFF0000, 32'h0F0F0F0F, 4'h9);
    out_ready = 1'b0;
    wait_valid(n);
    chk("b2b_latency", 64'(n), 64'd5);
    chk("b2b_vec", 64'(out_vec), 64'hF0F00F0F);
    chk("b2b_dest", 64'(out_dest), 64'h9);
    pop();

    // Flush while the third lane is in the ALU
    send(3'b010, 32'hA5A5A5A5, 32'h11111111, 4'hA);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    count_valid(8, seen);
    chk("flush_no_valid", 64'(seen), 64'd0);
    step();
    run_vec(3'b010, 32'h01020304, 32'h01010101, 4'hB, n);
    chk("post_flush_latency", 64'(n), 64'd5);
    chk("post_flush_vec", 64'(out_vec), 64'h02030405);
    chk("post_flush_masks", 64'({out_neg_mask, out_zero_mask}), 64'd0);

    // Reset while a result is held in DONE
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rstdone_valid", 64'(out_valid), 64'd0);
    chk("rstdone_vec", 64'(out_vec), 64'd0);
    chk("rstdone_masks", 64'({out_neg_mask, out_zero_mask}), 64'd0);
    chk("rstdone_dest", 64'(out_dest), 64'd0);
    chk("rstdone_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstdone_ready_after", 64'(in_ready), 64'd1);
    step();

    // Flush and in_valid together in IDLE: nothing is accepted
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'b010; in_vec_a = 32'h01010101; in_vec_b = 32'h01010101;
    @(negedge clk);
    chk("flush_idle_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    count_valid(7, seen);
    chk("flush_idle_no_valid", 64'(seen), 64'd0);
    step();

    // Randomized traffic with backpressure and occasional flush
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      flush = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 1) == 1);
        in_op    = 3'($urandom);
        in_vec_a = VW'($urandom);
        in_vec_b = VW'($urandom);
        if ($urandom_range(0, 1) == 1) in_vec_b = in_vec_b & 32'h0F0F0F0F;
        in_dest  = RW'($urandom);
      end
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_exec_sequencer.md
Name: vector_exec_sequencer

Overview:
- Execute-stage sequencer for the vector ASIP.
- Accepts one vector instruction: opcode, two packed operand vectors and a destination register address.
- Streams the lanes one per cycle through a single shared `alu` instance and collects per-lane results and flags into a packed result vector.
- Hands the completed vector to the memory/writeback stage over a valid/ready handshake.

Parameters:
- dataSize, 8, element width in bits; passed to the `alu` instance.
- lanes, 4, number of elements per vector; must be >= 2.
- regAddrSize, 4, destination register address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; drops any in-flight vector.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  sequencer can accept.
- in_op  input  3  ALU operation_select code.
- in_vec_a  input  lanes*dataSize  operand 1 vector; lane i is bits [i*dataSize +: dataSize].
- in_vec_b  input  lanes*dataSize  operand 2 vector.
- in_dest  input  regAddrSize  destination register.
- out_valid  output  1  result vector available.
- out_ready  input  1  downstream accepts.
- out_vec  output  lanes*dataSize  result vector, same lane packing.
- out_neg_mask  output  lanes  per-lane neg_flag.
- out_zero_mask  output  lanes  per-lane zero_flag.
- out_dest  output  regAddrSize  captured in_dest.

Behaviour:
- Reset and control:
  - One clock domain. Reset is synchronous, active-high.
  - rst takes priority over flush; flush takes priority over in_valid.
- FSM states: IDLE, RUN, DONE.
  - Registered lane counter: lane_cnt, width clog2(lanes).
- Reset values:
  - state=IDLE, lane_cnt=0.
  - out_valid=0, out_vec=0, out_neg_mask=0, out_zero_mask=0, out_dest=0.
  - in_ready=0 while rst=1.
- Acceptance:
  - in_ready = !rst && !flush && (state==IDLE || (state==DONE && out_ready)).
  - Accept = in_valid && in_ready. On accept: capture op, vec_a, vec_b and dest; set lane_cnt=0; clear out_vec and both masks; next state RUN.
- RUN:
  - Each cycle drive lane lane_cnt of vec_a/vec_b into the alu.
  - Register the result into out_vec lane lane_cnt, neg_flag into out_neg_mask[lane_cnt], and zero_flag into out_zero_mask[lane_cnt].
  - If lane_cnt==lanes-1, go to DONE; else lane_cnt+1.
  - in_ready=0 in RUN.
- DONE:
  - out_valid=1. All outputs are held stable until out_ready=1.
  - On out_ready with no accept, go to IDLE.
  - On out_ready with a simultaneous accept, go directly to RUN (back-to-back).
- Latency and throughput:
  - Accept on edge T gives out_valid=1 in the cycle after edge T+lanes, i.e. lanes+1 cycles after the accept cycle.
  - Sustained throughput is one vector per lanes+1 cycles.
- Arithmetic: exactly the alu semantics.
  - Opcodes: 001 xor, 010 add, 011 sub, 100 mul, 101 shr, 110 shl, 111 inc (operand1+1), 000 result 0.
  - All results are truncated to dataSize bits, with no saturation.
  - Shift amount is the full operand2; an amount >= dataSize gives 0.
  - zero = result==0.
  - neg = (op1 msb != result msb) && !zero.
- Flush: in any state, go to IDLE next cycle with out_valid=0. The partial vector is discarded; data outputs keep their values and are don't-care.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; upstream must hold its data.

Decomposition:
- Shared package: opcode localparams (OP_NOP..OP_INC, 3-bit) and the FSM state enum; the same package is used by decode.
- Sub-module: the existing `alu`, instantiated once with dataSize.
- Lane slicing and counting stay inline.

Test Plan:
- Add, lanes=4, dataSize=8: a={0x10,0xFF,0x7F,0x01}, b={0xF0,0x01,0x01,0x01} (lane3..lane0) -> out_vec={0x00,0x00,0x80,0x02}, out_zero_mask=4'b1100, out_neg_mask=4'b0010; out_valid rises 5 cycles after the accept cycle.
- Sub/mul/shr: sub 0x05-0x06 -> 0xFF with neg=1; mul 0x10*0x10 -> 0x00 with zero=1; shr 0x80>>9 -> 0x00; op 000 -> all zeros, zero_mask=1111, neg_mask=0000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and all outputs stable, in_ready=0. Then out_ready=1 and in_valid=1 in the same cycle -> second vector accepted with no IDLE bubble, and its result is correct.
- Flush during RUN at lane_cnt=2 -> IDLE next cycle, no out_valid pulse. A following add vector produces the correct result with no stale lanes.
- Reset in DONE with out_valid=1 -> next cycle out_valid=0, outputs and masks 0, in_ready=1 once rst deasserts.
- Flush and in_valid together in IDLE -> no accept, in_ready=0 that cycle.
